int_timers: RTL and testbench

INT_TIMERS -- requirements
Module: int_timers

---
 rtl/int_pkg.sv | 32 +++
 rtl/int_timer_ch.sv | 79 +++++++
 rtl/int_timers.sv | 80 ++++++++
 tb/tb_int_timers.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// ---------------------------------------------------------------------------
// int_pkg -- shared constants for the interrupt timer block and the interrupt
// controller integration: register map, ctrl bit positions, channel count.
// ---------------------------------------------------------------------------
package int_pkg;

    localparam int unsigned NUM_CH = 3;

    typedef enum logic [2:0] {
        ADDR_CTRL     = 3'd0,
        ADDR_PRESCALE = 3'd1,
        ADDR_CH0_LO   = 3'd2,
        ADDR_CH0_HI   = 3'd3,
        ADDR_CH1_LO   = 3'd4,
        ADDR_CH1_HI   = 3'd5,
        ADDR_CH2_LO   = 3'd6,
        ADDR_CH2_HI   = 3'd7
    } reg_addr_e;

    // ctrl register layout: enable bits at [2:0], one-shot mode bits at [6:4]
    localparam int unsigned CTRL_ENA_LSB  = 0;
    localparam int unsigned CTRL_MODE_LSB = 4;

    function automatic logic [2:0] reload_lo_addr(input int unsigned ch);
        return 3'(int'(ADDR_CH0_LO) + 2 * ch);
    endfunction

    function automatic logic [2:0] reload_hi_addr(input int unsigned ch);
        return 3'(int'(ADDR_CH0_HI) + 2 * ch);
    endfunction

endpackage

// File: rtl/int_timer_ch.sv
// ---------------------------------------------------------------------------
// int_timer_ch -- one timer channel: reload shadow/register, 16-bit down
// counter, enable/mode bits with one-shot auto-clear, registered strobe.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   i_tick          shared prescaler tick
//   i_ctrl_we       ctrl register write this cycle
//   i_ena_wr        enable bit being written
//   i_mode_wr       mode bit being written (1 = one-shot)
//   i_lo_we/i_hi_we reload lo / hi byte write
//   i_din           write data
//   o_ena, o_mode   current enable / mode bits
//   o_stb           one-cycle expiry strobe
// ---------------------------------------------------------------------------
module int_timer_ch (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick,
    input  logic       i_ctrl_we,
    input  logic       i_ena_wr,
    input  logic       i_mode_wr,
    input  logic       i_lo_we,
    input  logic       i_hi_we,
    input  logic [7:0] i_din,
    output logic       o_ena,
    output logic       o_mode,
    output logic       o_stb
);

    logic [7:0]  r_shadow;
    logic [15:0] r_reload;
    logic [15:0] r_count;
    logic        r_ena;
    logic        r_mode;
    logic        r_stb;

    logic        w_rise;
    logic        w_expire;

    // Enable edge reloads the counter and overrides any coincident tick.
    assign w_rise   = i_ctrl_we & i_ena_wr & ~r_ena;
    assign w_expire = i_tick & r_ena & (r_count == '0) & ~w_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_reload <= '0;
            r_count  <= '0;
            r_ena    <= 1'b0;
            r_mode   <= 1'b0;
            r_stb    <= 1'b0;
        end else begin
            if (i_lo_we)
                r_shadow <= i_din;
            if (i_hi_we)
                r_reload <= {i_din, r_shadow};

            if (w_rise)
                r_count <= r_reload;
            else if (i_tick && r_ena)
                r_count <= (r_count == '0) ? r_reload : r_count - 16'd1;

            // A ctrl write in the expiry cycle wins over the one-shot clear.
            if (i_ctrl_we) begin
                r_ena  <= i_ena_wr;
                r_mode <= i_mode_wr;
            end else if (w_expire && r_mode) begin
                r_ena <= 1'b0;
            end

            r_stb <= w_expire;
        end
    end

    assign o_ena  = r_ena;
    assign o_mode = r_mode;
    assign o_stb  = r_stb;

endmodule

// File: rtl/int_timers.sv
// ---------------------------------------------------------------------------
// int_timers -- three programmable interval timers sharing one prescaler,
// producing one-cycle interrupt request strobes.
// Ports:
//   clk       system clock (rising edge)
//   rst_n     async active-low reset
//   wr_stb    one-cycle register write strobe
//   addr      register select (see int_pkg::reg_addr_e)
//   din       write data
//   rd_data   status {2'b00, mode[2:0], ena[2:0]}
//   int_stbs  registered per-channel interrupt strobes
// ---------------------------------------------------------------------------
module int_timers
    import int_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_stb,
    input  logic [2:0]        addr,
    input  logic [7:0]        din,
    output logic [7:0]        rd_data,
    output logic [NUM_CH-1:0] int_stbs
);

    logic [7:0]        r_prescale;
    logic [7:0]        r_pre_cnt;

    logic              w_tick;
    logic              w_ctrl_we;
    logic              w_pre_we;
    logic [NUM_CH-1:0] w_ena;
    logic [NUM_CH-1:0] w_mode;
    logic [NUM_CH-1:0] w_stb;

    assign w_ctrl_we = wr_stb && (addr == ADDR_CTRL);
    assign w_pre_we  = wr_stb && (addr == ADDR_PRESCALE);
    assign w_tick    = (r_pre_cnt == '0);

    // A new prescale value is only picked up at the next reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale <= '0;
            r_pre_cnt  <= '0;
        end else begin
            if (w_tick)
                r_pre_cnt <= r_prescale;
            else
                r_pre_cnt <= r_pre_cnt - 8'd1;
            if (w_pre_we)
                r_prescale <= din;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_lo_we;
        logic w_hi_we;

        assign w_lo_we = wr_stb && (addr == reload_lo_addr(g));
        assign w_hi_we = wr_stb && (addr == reload_hi_addr(g));

        int_timer_ch u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_tick    (w_tick),
            .i_ctrl_we (w_ctrl_we),
            .i_ena_wr  (din[CTRL_ENA_LSB + g]),
            .i_mode_wr (din[CTRL_MODE_LSB + g]),
            .i_lo_we   (w_lo_we),
            .i_hi_we   (w_hi_we),
            .i_din     (din),
            .o_ena     (w_ena[g]),
            .o_mode    (w_mode[g]),
            .o_stb     (w_stb[g])
        );
    end

    assign rd_data  = {2'b00, w_mode, w_ena};
    assign int_stbs = w_stb;

endmodule

// File: tb/tb_int_timers.sv
module tb_int_timers;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_stb = 1'b0;
    logic [2:0] addr = '0;
    logic [7:0] din = '0;
    logic [7:0] rd_data;
    logic [2:0] int_stbs;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    int_timers dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_stb   (wr_stb),
        .addr     (addr),
        .din      (din),
        .rd_data  (rd_data),
        .int_stbs (int_stbs)
    );

    // Reference model: prescaler as an up-counting phase within the current
    // tick period; each channel counts elapsed ticks against a target period
    // captured whenever it (re)starts.
    int m_P, m_plen, m_phase;
    int m_R[3], m_sh[3], m_elapsed[3], m_target[3];
    bit m_ena[3], m_mode[3], m_stb[3];
    bit mt, mctrl, mrise, mfire;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_P = 0; m_plen = 0; m_phase = 0;
            for (int i = 0; i < 3; i++) begin
                m_R[i] = 0; m_sh[i] = 0; m_elapsed[i] = 0; m_target[i] = 0;
                m_ena[i] = 0; m_mode[i] = 0; m_stb[i] = 0;
            end
        end else begin
            mt    = (m_phase == m_plen);
            mctrl = wr_stb && (addr == 3'd0);
            for (int i = 0; i < 3; i++) begin
                mrise = mctrl && din[i] && !m_ena[i];
                mfire = mt && m_ena[i] && !mrise && (m_elapsed[i] == m_target[i]);
                m_stb[i] = mfire;
                if (mrise) begin
                    m_elapsed[i] = 0; m_target[i] = m_R[i];
                end else if (mt && m_ena[i]) begin
                    if (mfire) begin
                        m_elapsed[i] = 0; m_target[i] = m_R[i];
                    end else begin
                        m_elapsed[i]++;
                    end
                end
                if (mctrl) begin
                    m_ena[i] = din[i]; m_mode[i] = din[4+i];
                end else if (mfire && m_mode[i]) begin
                    m_ena[i] = 0;
                end
            end
            if (mt) begin
                m_phase = 0; m_plen = m_P;
            end else begin
                m_phase++;
            end
            if (wr_stb) begin
                if (addr == 3'd1)
                    m_P = int'(din);
                else if (addr >= 3'd2 && addr[0] == 1'b0)
                    m_sh[(int'(addr) - 2) / 2] = int'(din);
                else if (addr >= 3'd3)
                    m_R[(int'(addr) - 3) / 2] = int'(din) * 256 + m_sh[(int'(addr) - 3) / 2];
            end
        end
    end

    function automatic logic [7:0] m_rd();
        return {2'b00, m_mode[2], m_mode[1], m_mode[0], m_ena[2], m_ena[1], m_ena[0]};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        chk("model_stbs", {5'b0, int_stbs}, {5'b0, m_stb[2], m_stb[1], m_stb[0]});
        chk("model_rd", rd_data, m_rd());
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        addr = a; din = d; wr_stb = 1'b1;
        cyc();
        wr_stb = 1'b0;
    endtask

    task automatic do_reset();
        wr_stb = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_stb(input int ch, input int budget, output int n);
        bit seen;
        seen = 0; n = 0;
        while (!seen && n < budget) begin
            cyc();
            n++;
            if (int_stbs[ch]) seen = 1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL wait_stb ch%0d: no strobe within %0d cycles", ch, budget);
        end
    endtask

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[8];
    int   n, cnt;
    logic [2:0] ra;
    logic [7:0] rdv;

    initial begin
        vecs[0] = '{3'd1, 8'd200, 8'h00};
        vecs[1] = '{3'd0, 8'h01, 8'h01};
        vecs[2] = '{3'd0, 8'h77, 8'h3F};
        vecs[3] = '{3'd0, 8'h70, 8'h38};
        vecs[4] = '{3'd0, 8'h25, 8'h15};
        vecs[5] = '{3'd0, 8'h88, 8'h00};
        vecs[6] = '{3'd2, 8'h55, 8'h00};
        vecs[7] = '{3'd0, 8'h12, 8'h0A};

        // reset state
        do_reset();
        chk("reset_stbs", {5'b0, int_stbs}, 8'h00);
        chk("reset_rd", rd_data, 8'h00);

        // register map / status readback
        for (int i = 0; i < 8; i++) begin
            wr(vecs[i].a, vecs[i].d);
            chk($sformatf("table_rd[%0d]", i), rd_data, vecs[i].exp_rd);
        end

        // P=0, ch0 R=4: every 5 clocks, 1 cycle wide
        do_reset();
        wr(3'd2, 8'd4); wr(3'd3, 8'd0); wr(3'd0, 8'h01);
        wait_stb(0, 20, n);
        chk_int("ch0_first_latency", n, 5);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("ch0_width", {7'b0, int_stbs[0]}, 8'h00);
            wait_stb(0, 20, n);
            chk_int("ch0_period", n + 1, 5);
        end

        // P=3, ch1 R=2 periodic: period 12
        do_reset();
        wr(3'd1, 8'd3); wr(3'd4, 8'd2); wr(3'd5, 8'd0); wr(3'd0, 8'h02);
        chk("ch1_rd", rd_data, 8'h02);
        wait_stb(1, 40, n);
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("ch1_width", {7'b0, int_stbs[1]}, 8'h00);
            wait_stb(1, 40, n);
            chk_int("ch1_period", n + 1, 12);
        end

        // ch2 one-shot, R=1, P=0
        do_reset();
        wr(3'd6, 8'd1); wr(3'd7, 8'd0); wr(3'd0, 8'h44);
        chk("ch2_rd_armed", rd_data, 8'h24);
        wait_stb(2, 10, n);
        chk_int("ch2_oneshot_latency", n, 2);
        cyc();
        chk("ch2_rd_cleared", rd_data, 8'h20);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (int_stbs != 3'b000) cnt++;
        end
        chk_int("ch2_no_more_stb", cnt, 0);

        // reload change while running: current period finishes first
        do_reset();
        wr(3'd2, 8'd9); wr(3'd3, 8'd0); wr(3'd0, 8'h01);
        wait_stb(0, 20, n);
        wr(3'd2, 8'd3); wr(3'd3, 8'd0);
        wait_stb(0, 20, n);
        chk_int("reload_old_period", n + 2, 10);
        wait_stb(0, 20, n);
        chk_int("reload_new_period", n, 4);
        wr(3'd2, 8'd7);
        wait_stb(0, 20, n);
        chk_int("lo_only_no_effect", n + 1, 4);

        // all channels R=0, P=1
        do_reset();
        wr(3'd1, 8'd1); wr(3'd0, 8'h07);
        wait_stb(0, 10, n);
        chk("all_first", {5'b0, int_stbs}, 8'h07);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("all_gap", {5'b0, int_stbs}, 8'h00);
            cyc();
            chk("all_pulse", {5'b0, int_stbs}, 8'h07);
        end

        // reset mid-count while a strobe is high
        do_reset();
        wr(3'd2, 8'd3); wr(3'd3, 8'd0); wr(3'd0, 8'h01);
        wait_stb(0, 20, n);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_stbs", {5'b0, int_stbs}, 8'h00);
        chk("midreset_rd", rd_data, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (int_stbs != 3'b000) cnt++;
        end
        chk_int("post_reset_quiet", cnt, 0);

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(3) == 0) begin
                ra  = 3'($urandom_range(7));
                rdv = 8'($urandom);
                if (ra == 3'd1)
                    rdv = 8'($urandom_range(3));
                else if (ra >= 3'd2 && ra[0] == 1'b0)
                    rdv = 8'($urandom_range(15));
                else if (ra >= 3'd3)
                    rdv = 8'd0;
                wr(ra, rdv);
            end else begin
                cyc();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
